// File: rtl/scc_pkg.sv
// Shared constants and types for the SCC wave scheduler.
// Frame: 5 channel fetch slots followed by 3 CPU slots.
package scc_pkg;
  localparam int CH_SLOTS = 5;
  localparam int FRAME    = 8;
  localparam int FREQ_W   = 12;
  localparam int PTR_W    = 5;

  // Wave-RAM address: 32-byte table per channel
  typedef struct packed {
    logic [2:0]       ch;
    logic [PTR_W-1:0] idx;
  } wave_addr_t;
endpackage

// File: rtl/scc_wave_counter.sv
// Per-channel period counter and wave-table pointer.
// Steps only in the channel's own slot; a key-on edge restarts the
// pointer at the channel's next slot.
module scc_wave_counter
  import scc_pkg::*;
#(
  parameter int FREQ_W = scc_pkg::FREQ_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              slot_hit_i,
  input  logic              en_i,
  input  logic              freq_we_i,
  input  logic [FREQ_W-1:0] freq_d_i,
  output logic [PTR_W-1:0]  ptr_o
);
  logic [FREQ_W-1:0] freq_q, freq_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              pend_q, pend_d, en_prev_q;
  logic              rise, start;

  assign rise  = en_i & ~en_prev_q;
  assign start = slot_hit_i & en_i & (pend_q | rise);
  assign ptr_o = ptr_q;

  // Next state: key-on restart, else reload/advance or decrement (old freq used on reload)
  always_comb begin
    freq_d = freq_we_i ? freq_d_i : freq_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    pend_d = pend_q;
    if (slot_hit_i && en_i) pend_d = 1'b0;
    else if (rise)          pend_d = 1'b1;
    if (start) begin
      cnt_d = freq_q;
      ptr_d = '0;
    end else if (slot_hit_i && en_i && freq_q != '0) begin
      if (cnt_q == '0) begin
        cnt_d = freq_q;
        ptr_d = ptr_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      freq_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      pend_q    <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      freq_q    <= freq_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      en_prev_q <= en_i;
    end
  end
endmodule

// File: rtl/scc_wave_scheduler.sv
// SCC wave-RAM scheduler: 8-cycle frame, slots 0..4 fetch one sample per
// channel, slots 5..7 carry at most one CPU access per frame.
// Option SCC_CH45_SHARE_EN: channel 4 reads channel 3's table and the
// 0x80..0x9F CPU window becomes write-ignored / read-as-0xFF.
module scc_wave_scheduler
  import scc_pkg::*;
#(
  parameter int SLOTS  = 8,
  parameter int FREQ_W = 12
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic [4:0]        ch_enable,
  input  logic              freq_we,
  input  logic [2:0]        freq_ch,
  input  logic [FREQ_W-1:0] freq_d,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_addr,
  input  logic [7:0]        cpu_d,
  output logic              cpu_ack,
  output logic [7:0]        cpu_q,
  output logic [7:0]        sram_addr,
  output logic              sram_we,
  output logic [7:0]        sram_d,
  input  logic [7:0]        sram_q,
  output logic              smp_valid,
  output logic [2:0]        smp_ch,
  output logic              smp_mute
);
  // Frame length is fixed; any other SLOTS value falls back to FRAME
  localparam int LAST = (SLOTS == FRAME) ? SLOTS - 1 : FRAME - 1;

  logic [2:0] slot_q, slot_d;
  logic       served_q, served_d;
  logic       ack_q, ack_rd_q, ack_ff_q;
  logic [7:0] cpu_q_q, rd_data;
  logic       smp_valid_q, smp_mute_q;
  logic [2:0] smp_ch_q, ch_sel;
  logic       ch_slot, cpu_go, blocked, ch_en_sel;
  wave_addr_t fetch_addr;
  logic [CH_SLOTS-1:0][PTR_W-1:0] ptr;

  for (genvar g = 0; g < CH_SLOTS; g++) begin : g_ch
    scc_wave_counter #(.FREQ_W(FREQ_W)) u_cnt (
      .clk       (clk),
      .nreset    (nreset),
      .slot_hit_i(slot_q == 3'(g)),
      .en_i      (ch_enable[g]),
      .freq_we_i (freq_we && freq_ch == 3'(g)),
      .freq_d_i  (freq_d),
      .ptr_o     (ptr[g])
    );
  end

`ifdef SCC_CH45_SHARE_EN
  assign blocked = (cpu_addr[7:5] == 3'd4);
`else
  assign blocked = 1'b0;
`endif

  assign ch_slot  = slot_q < 3'(CH_SLOTS);
  assign ch_sel   = ch_slot ? slot_q : 3'd0;
  assign cpu_go   = ~ch_slot & cpu_req & ~served_q;
  assign slot_d   = (slot_q == 3'(LAST)) ? 3'd0 : slot_q + 3'd1;
  assign served_d = ch_slot ? 1'b0 : (served_q | cpu_go);

  // Fetch address and key state of the channel owning this slot
  always_comb begin
    fetch_addr.ch  = ch_sel;
    fetch_addr.idx = '0;
    ch_en_sel      = 1'b0;
    for (int i = 0; i < CH_SLOTS; i++) begin
      if (ch_sel == 3'(i)) begin
        fetch_addr.idx = ptr[i];
        ch_en_sel      = ch_enable[i];
      end
    end
`ifdef SCC_CH45_SHARE_EN
    if (ch_sel == 3'd4) fetch_addr.ch = 3'd3;
`endif
  end

  assign sram_we   = cpu_go & cpu_we & ~blocked;
  assign sram_addr = ch_slot ? fetch_addr : (cpu_go ? cpu_addr : 8'h00);
  assign sram_d    = sram_we ? cpu_d : 8'h00;
  assign rd_data   = ack_ff_q ? 8'hFF : sram_q;
  assign cpu_q     = ack_rd_q ? rd_data : cpu_q_q;
  assign cpu_ack   = ack_q;
  assign smp_valid = smp_valid_q;
  assign smp_ch    = smp_ch_q;
  assign smp_mute  = smp_mute_q;

  // Slot counter and CPU service/ack tracking; reset aborts any pending ack
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q   <= '0;
      served_q <= 1'b0;
      ack_q    <= 1'b0;
      ack_rd_q <= 1'b0;
      ack_ff_q <= 1'b0;
      cpu_q_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      served_q <= served_d;
      ack_q    <= cpu_go;
      ack_rd_q <= cpu_go & ~cpu_we;
      ack_ff_q <= cpu_go & ~cpu_we & blocked;
      if (ack_rd_q) cpu_q_q <= rd_data;
    end
  end

  // Sample strobe, one cycle after the fetch slot to match sram_q latency
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      smp_valid_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_mute_q  <= 1'b0;
    end else begin
      smp_valid_q <= ch_slot;
      smp_ch_q    <= ch_sel;
      smp_mute_q  <= ch_slot & ~ch_en_sel;
    end
  end
endmodule

// File: doc/scc_wave_scheduler.md
SCC_WAVE_SCHEDULER -- requirements
Module: scc_wave_scheduler

Interface
REQ-001 Parameter: SLOTS, 8, frame length in clk cycles; fixed at 8, other values unsupported.
REQ-002 Parameter: FREQ_W, 12, frequency register and period counter width.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; every register uses its rising edge.
REQ-005 ch_enable  input  5  per-channel key-on; bit n enables channel n.
REQ-006 freq_we  input  1  one-cycle strobe writing freq_d into channel freq_ch.
REQ-007 freq_ch  input  3  target channel 0..4; values 5..7 ignored.
REQ-008 freq_d  input  FREQ_W  new period value.
REQ-009 cpu_req  input  1  CPU wave-RAM access request, held until cpu_ack.
REQ-010 cpu_we  input  1  1=write, 0=read; valid with cpu_req.
REQ-011 cpu_addr  input  8  wave-RAM address {ch[2:0],idx[4:0]}.
REQ-012 cpu_d  input  8  write data.
REQ-013 cpu_ack  output  1  one-cycle completion pulse.
REQ-014 cpu_q  output  8  read data, valid with cpu_ack.
REQ-015 sram_addr  output  8  wave-RAM address; sram_we  output  1; sram_d  output  8; sram_q  input  8 (signed sample, 1-cycle read latency).
REQ-016 smp_valid  output  1  high for one cycle when sram_q holds a channel sample.
REQ-017 smp_ch  output  3  channel number of the sample, aligned with smp_valid.
REQ-018 smp_mute  output  1  high with smp_valid when that channel is key-off.

Function
REQ-019 The 3-bit slot counter SHALL count 0..7 and wrap to 0; slots 0..4 are channel fetch slots, slots 5..7 are CPU slots.
REQ-020 In channel slot n, the block SHALL drive sram_addr={n,ptr[n]}, sram_we=0, and one cycle later assert smp_valid with smp_ch=n and smp_mute=~ch_enable[n].
REQ-021 In channel slot n with ch_enable[n]=1 and freq[n]!=0, cnt[n] SHALL decrement by 1; when cnt[n]==0 it SHALL instead reload freq[n] and increment ptr[n] modulo 32.
REQ-022 A key-off channel (ch_enable[n]=0) SHALL hold cnt[n] and ptr[n]; freq[n]==0 SHALL also hold both values.
REQ-023 A rising edge of ch_enable[n] SHALL clear ptr[n] to 0 and load cnt[n]=freq[n] at that channel's next slot.
REQ-024 freq_we SHALL update freq[n] on the next clock edge; cnt[n] keeps counting and picks up the new value at its next reload.
REQ-025 freq_we coinciding with channel n's reload SHALL reload cnt[n] with the old value; the new value applies from the following reload.
REQ-026 A pending cpu_req SHALL be serviced in the first CPU slot it is seen in, and at most one access SHALL be serviced per frame; a write drives sram_we=1, a read drives sram_we=0, and cpu_ack SHALL pulse one cycle after the slot.
REQ-027 cpu_q SHALL equal sram_q sampled in the cycle cpu_ack is high; for writes cpu_q holds its previous value.
REQ-028 Worst-case CPU latency, from request to ack, SHALL be 9 cycles; channel fetches SHALL never be delayed by CPU traffic.
REQ-029 When sram_we=0 outside a serviced slot, sram_d SHALL be 0.

Reset
REQ-030 While nreset=0: slot=0, all freq/cnt/ptr=0, cpu_ack=0, cpu_q=0, smp_valid=0, smp_ch=0, smp_mute=0, sram_we=0, sram_addr=0, sram_d=0.
REQ-031 A reset asserted mid-access SHALL abort that access without a cpu_ack; after release the first slot SHALL be slot 0.

Configuration
REQ-032 With SCC_CH45_SHARE_EN defined, channel 4 fetches SHALL use address {3'd3,ptr[4]} (shared table); CPU writes to addresses 0x80..0x9F SHALL be dropped but still acked, and reads of them SHALL return 0xFF.
REQ-033 Without SCC_CH45_SHARE_EN, all five channels SHALL own separate 32-byte tables and all 160 addresses are CPU read/write.

Structure
REQ-034 A shared package scc_pkg SHALL hold the slot constants (CH_SLOTS=5, FRAME=8), FREQ_W, and the wave-address type.
REQ-035 Per-channel counter/pointer logic SHALL be a sub-module, scc_wave_counter, instantiated 5 times; scc_channel_volume consumes sram_q and smp_valid directly.

Verification
REQ-036 Scenario: freq[0]=2, ch_enable=1 -> ptr[0] advances every 3 frames (24 cycles); the address sequence is 0x00,0x01,0x02.
REQ-037 Scenario: CPU write of 0x5A to 0x23, then a read of 0x23 -> both acks within 9 cycles, cpu_q=0x5A, and channel slot timing is unchanged.
REQ-038 Scenario: ch_enable[2] toggled 0->1 with ptr[2]=17 -> the next fetch for channel 2 uses address 0x40.
REQ-039 Scenario: freq_we on the reload cycle of channel 1 (old 5, new 9) -> the next period is 6 frames, the one after is 10 frames.
REQ-040 Scenario: with SCC_CH45_SHARE_EN, a write of 0x80 -> ack with no sram_we; a channel 4 fetch shows sram_addr[7:5]=3.
REQ-041 Scenario: nreset pulsed during a CPU slot -> no cpu_ack, and all outputs return to their reset values.
